// File: rtl/ex_stage_ctrl_if.sv
// ex_stage_ctrl_if: signal bundle around the EX stage controller.
// Carries the decode handshake, the registered drive to the Execute datapath,
// the combinational Execute returns, the memory-stage handoff and the branch redirect.
// master: the EX stage controller. slave: decode / Execute / memory / fetch side.
interface ex_stage_ctrl_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic [31:0] id_imm;
    logic [31:0] id_pc_next;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [2:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_branch;

    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc_next;
    logic [4:0]  ex_shamt;
    logic [5:0]  ex_funct;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src;

    logic [31:0] ex_result;
    logic [31:0] ex_add_result;
    logic        ex_zero;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_result;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        input  id_valid, id_a, id_b, id_imm, id_pc_next, id_shamt, id_funct, id_alu_op,
               id_alu_src, id_branch,
        output id_ready,
        output ex_a, ex_b, ex_imm, ex_pc_next, ex_shamt, ex_funct, ex_alu_op, ex_alu_src,
        input  ex_result, ex_add_result, ex_zero,
        output mem_valid, mem_result,
        input  mem_ready,
        output redirect_valid, redirect_pc
    );

    modport slave (
        output id_valid, id_a, id_b, id_imm, id_pc_next, id_shamt, id_funct, id_alu_op,
               id_alu_src, id_branch,
        input  id_ready,
        input  ex_a, ex_b, ex_imm, ex_pc_next, ex_shamt, ex_funct, ex_alu_op, ex_alu_src,
        output ex_result, ex_add_result, ex_zero,
        input  mem_valid, mem_result,
        output mem_ready,
        input  redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl: one-entry Execute pipeline stage controller.
// Registers the decoded instruction toward the Execute datapath, hands the result to the
// memory stage with a valid/ready handshake and raises a fetch redirect on a taken branch.
// Optional feature: define EX_STAGE_CTRL_MUL_EN to add a shift-add multiplier
// (alu_op 3'b010, funct 6'h18) iterating MUL_CYCLES cycles before handoff.
module ex_stage_ctrl #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ex_stage_ctrl_if.master        ex_if
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1
`ifdef EX_STAGE_CTRL_MUL_EN
        ,
        StMul   = 2'd2
`endif
    } state_e;

    state_e      state_q, state_d;

    logic [31:0] ex_a_q, ex_a_d;
    logic [31:0] ex_b_q, ex_b_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [31:0] ex_pc_next_q, ex_pc_next_d;
    logic [4:0]  ex_shamt_q, ex_shamt_d;
    logic [5:0]  ex_funct_q, ex_funct_d;
    logic [2:0]  ex_alu_op_q, ex_alu_op_d;
    logic        ex_alu_src_q, ex_alu_src_d;
    logic        ex_branch_q, ex_branch_d;

    logic        full;
    logic        redirect;
    logic        id_ready;
    logic        xfer_in;
    state_e      accept_state;
    logic [31:0] mem_result;

`ifdef EX_STAGE_CTRL_MUL_EN
    localparam logic [5:0] LastCnt = 6'(MUL_CYCLES - 1);

    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        mul_res_q, mul_res_d;
    logic        mul_op_in;
`endif

    // Handshake, redirect and where an accepted instruction goes.
    always_comb begin
        full     = (state_q == StFull);
        // Taken branch retires this cycle; the younger instruction must wait for the flush.
        redirect = full && ex_branch_q && ex_if.ex_zero && ex_if.mem_ready;
        id_ready = (state_q == StEmpty) || (full && ex_if.mem_ready && !redirect);
        xfer_in  = ex_if.id_valid && id_ready;
        accept_state = StFull;
`ifdef EX_STAGE_CTRL_MUL_EN
        mul_op_in = (ex_if.id_alu_op == 3'b010) && (ex_if.id_funct == 6'h18);
        if (mul_op_in) begin
            accept_state = StMul;
        end
`endif
    end

    // Next-state logic of the stage FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (xfer_in) begin
                    state_d = accept_state;
                end
            end
            StFull: begin
                if (xfer_in) begin
                    state_d = accept_state;
                end else if (ex_if.mem_ready) begin
                    state_d = StEmpty;
                end
            end
`ifdef EX_STAGE_CTRL_MUL_EN
            StMul: begin
                if (cnt_q == LastCnt) begin
                    state_d = StFull;
                end
            end
`endif
            default: state_d = StEmpty;
        endcase
    end

    // Operand registers load only on a transfer in, so they hold while the handoff stalls.
    always_comb begin
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_imm_d     = ex_imm_q;
        ex_pc_next_d = ex_pc_next_q;
        ex_shamt_d   = ex_shamt_q;
        ex_funct_d   = ex_funct_q;
        ex_alu_op_d  = ex_alu_op_q;
        ex_alu_src_d = ex_alu_src_q;
        ex_branch_d  = ex_branch_q;
        if (xfer_in) begin
            ex_a_d       = ex_if.id_a;
            ex_b_d       = ex_if.id_b;
            ex_imm_d     = ex_if.id_imm;
            ex_pc_next_d = ex_if.id_pc_next;
            ex_shamt_d   = ex_if.id_shamt;
            ex_funct_d   = ex_if.id_funct;
            ex_alu_op_d  = ex_if.id_alu_op;
            ex_alu_src_d = ex_if.id_alu_src;
            ex_branch_d  = ex_if.id_branch;
        end
    end

`ifdef EX_STAGE_CTRL_MUL_EN
    // Shift-add multiply: one multiplier bit per cycle while in StMul.
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        mul_res_d = mul_res_q;
        if (xfer_in) begin
            mcand_d   = ex_if.id_a;
            mplier_d  = ex_if.id_b;
            prod_d    = '0;
            cnt_d     = '0;
            mul_res_d = mul_op_in;
        end else if (state_q == StMul) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = (cnt_q == LastCnt) ? 6'd0 : cnt_q + 6'd1;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            mul_res_q <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            mul_res_q <= mul_res_d;
        end
    end
`endif

    // Result toward memory: the product for a multiply, otherwise the Execute ALU result.
    always_comb begin
        mem_result = '0;
        if (full) begin
            mem_result = ex_if.ex_result;
`ifdef EX_STAGE_CTRL_MUL_EN
            if (mul_res_q) begin
                mem_result = prod_q;
            end
`endif
        end
    end

    // Stage state and operand registers; reset discards any entry in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_pc_next_q <= '0;
            ex_shamt_q   <= '0;
            ex_funct_q   <= '0;
            ex_alu_op_q  <= '0;
            ex_alu_src_q <= 1'b0;
            ex_branch_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_next_q <= ex_pc_next_d;
            ex_shamt_q   <= ex_shamt_d;
            ex_funct_q   <= ex_funct_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_alu_src_q <= ex_alu_src_d;
            ex_branch_q  <= ex_branch_d;
        end
    end

    assign ex_if.id_ready       = id_ready;
    assign ex_if.ex_a           = ex_a_q;
    assign ex_if.ex_b           = ex_b_q;
    assign ex_if.ex_imm         = ex_imm_q;
    assign ex_if.ex_pc_next     = ex_pc_next_q;
    assign ex_if.ex_shamt       = ex_shamt_q;
    assign ex_if.ex_funct       = ex_funct_q;
    assign ex_if.ex_alu_op      = ex_alu_op_q;
    assign ex_if.ex_alu_src     = ex_alu_src_q;
    assign ex_if.mem_valid      = full;
    assign ex_if.mem_result     = mem_result;
    assign ex_if.redirect_valid = redirect;
    assign ex_if.redirect_pc    = ex_if.ex_add_result;

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb_ex_stage_ctrl: bench for ex_stage_ctrl with a combinational Execute model
// and a scoreboard of expected memory-stage results and redirects.
module tb_ex_stage_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ex_stage_ctrl_if bus ();

    ex_stage_ctrl #(.MUL_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        taken;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];

    // Execute-stage ALU model.
    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm, input logic [2:0] op,
                                        input logic [5:0] funct, input logic src);
        logic [31:0] bb;
        bb = src ? imm : b;
        case (op)
            3'b000: return a + bb;
            3'b001: return a - bb;
            3'b010: begin
                case (funct)
                    6'h22:   return a - bb;
                    6'h24:   return a & bb;
                    6'h25:   return a | bb;
                    default: return a + bb;
                endcase
            end
            default: return a + bb;
        endcase
    endfunction

    // Execute datapath driven from the registered ex_* outputs.
    always_comb begin
        bus.ex_result     = alu(bus.ex_a, bus.ex_b, bus.ex_imm, bus.ex_alu_op, bus.ex_funct,
                                bus.ex_alu_src);
        bus.ex_zero       = ((bus.ex_a - (bus.ex_alu_src ? bus.ex_imm : bus.ex_b)) == 32'd0);
        bus.ex_add_result = bus.ex_pc_next + (bus.ex_imm << 2);
    end

    // Expected handoff for an instruction accepted with the current id_* values.
    function automatic exp_t exp_of();
        exp_t e;
        logic [31:0] bb;
        bb      = bus.id_alu_src ? bus.id_imm : bus.id_b;
        e.res   = alu(bus.id_a, bus.id_b, bus.id_imm, bus.id_alu_op, bus.id_funct,
                      bus.id_alu_src);
`ifdef EX_STAGE_CTRL_MUL_EN
        if (bus.id_alu_op == 3'b010 && bus.id_funct == 6'h18) e.res = bus.id_a * bus.id_b;
`endif
        e.taken = bus.id_branch && ((bus.id_a - bb) == 32'd0);
        e.rpc   = bus.id_pc_next + (bus.id_imm << 2);
        return e;
    endfunction

    // Scoreboard: pop on each handoff, push on each acceptance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.mem_valid && bus.mem_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_handoff: mem_result=%h, expected no handoff",
                             bus.mem_result);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.mem_result !== e.res) begin
                        n_err++;
                        $display("FAIL sb_mem_result: got %h expected %h", bus.mem_result, e.res);
                    end
                    n_vec++;
                    if (bus.redirect_valid !== e.taken) begin
                        n_err++;
                        $display("FAIL sb_redirect_valid: got %b expected %b",
                                 bus.redirect_valid, e.taken);
                    end
                    if (e.taken) begin
                        n_vec++;
                        if (bus.redirect_pc !== e.rpc) begin
                            n_err++;
                            $display("FAIL sb_redirect_pc: got %h expected %h",
                                     bus.redirect_pc, e.rpc);
                        end
                        n_vec++;
                        if (bus.id_ready !== 1'b0) begin
                            n_err++;
                            $display("FAIL sb_redirect_id_ready: got %b expected 0", bus.id_ready);
                        end
                    end
                end
            end else begin
                n_vec++;
                if (bus.redirect_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL sb_stray_redirect: got %b expected 0", bus.redirect_valid);
                end
            end
            if (bus.id_valid && bus.id_ready) exp_q.push_back(exp_of());
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [2:0] op, input logic [5:0] funct,
                         input logic src, input logic br);
        bus.id_valid   = 1'b1;
        bus.id_a       = a;
        bus.id_b       = b;
        bus.id_imm     = imm;
        bus.id_pc_next = pc;
        bus.id_alu_op  = op;
        bus.id_funct   = funct;
        bus.id_alu_src = src;
        bus.id_branch  = br;
        bus.id_shamt   = a[4:0];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.id_valid = 1'b0;
        bus.mem_ready = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 6'd0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mem_valid_in_reset: got %b expected 0", bus.mem_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_id_ready: got %b expected 1", bus.id_ready);
        end
        n_vec++;
        if (bus.redirect_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_redirect: got %b expected 0", bus.redirect_valid);
        end
        n_vec++;
        if (bus.mem_result !== 32'd0) begin
            n_err++; $display("FAIL reset_mem_result: got %h expected 0", bus.mem_result);
        end
        n_vec++;
        if ({bus.ex_a, bus.ex_b, bus.ex_pc_next, bus.ex_alu_op} !== 99'd0) begin
            n_err++; $display("FAIL reset_ex_regs: ex_a=%h ex_pc_next=%h expected 0",
                              bus.ex_a, bus.ex_pc_next);
        end
        next_cycle();
    endtask

    task automatic test_single_add();
        drive(32'd5, 32'd7, 32'd0, 32'h40, 3'b010, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL add_id_ready: got %b expected 1", bus.id_ready);
        end
        next_cycle();
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'd12) begin
            n_err++; $display("FAIL add_latency: mem_valid=%b mem_result=%h expected 1/0000000c",
                              bus.mem_valid, bus.mem_result);
        end
        n_vec++;
        if (bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7) begin
            n_err++; $display("FAIL add_ex_regs: ex_a=%h ex_b=%h expected 5/7", bus.ex_a, bus.ex_b);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b0) begin
            n_err++; $display("FAIL add_drain: mem_valid=%b expected 0", bus.mem_valid);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [4] = '{32'd10, 32'hF0, 32'hF0, 32'd1};
        logic [31:0] bv [4] = '{32'd3, 32'h3C, 32'h0F, 32'd0};
        logic [5:0]  fv [4] = '{6'h22, 6'h24, 6'h25, 6'h20};
        logic [2:0]  ov [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
        for (int i = 0; i < 4; i++) begin
            drive(av[i], bv[i], 32'h10, 32'h80, ov[i], fv[i], (i == 3), 1'b0);
            @(negedge clk);
            n_vec++;
            if (bus.id_ready !== 1'b1) begin
                n_err++; $display("FAIL stream_id_ready[%0d]: got %b expected 1", i, bus.id_ready);
            end
            if (i > 0) begin
                n_vec++;
                if (bus.mem_valid !== 1'b1) begin
                    n_err++; $display("FAIL stream_bubble[%0d]: mem_valid=%b expected 1",
                                      i, bus.mem_valid);
                end
            end
            next_cycle();
        end
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'h11) begin
            n_err++; $display("FAIL stream_last: mem_valid=%b mem_result=%h expected 1/00000011",
                              bus.mem_valid, bus.mem_result);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_drain: mem_valid=%b expected 0", bus.mem_valid);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        bus.mem_ready = 1'b0;
        drive(32'h1234, 32'h1111, 32'h0, 32'h0, 3'b010, 6'h20, 1'b0, 1'b0);
        next_cycle();
        drive(32'd7, 32'd8, 32'h0, 32'h0, 3'b010, 6'h20, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.id_ready !== 1'b0 || bus.mem_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_handshake[%0d]: id_ready=%b mem_valid=%b expected 0/1",
                                  i, bus.id_ready, bus.mem_valid);
            end
            n_vec++;
            if (bus.mem_result !== 32'h2345 || bus.ex_a !== 32'h1234) begin
                n_err++; $display("FAIL stall_hold[%0d]: mem_result=%h ex_a=%h expected 2345/1234",
                                  i, bus.mem_result, bus.ex_a);
            end
            next_cycle();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release: id_ready=%b expected 1", bus.id_ready);
        end
        next_cycle();
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'd15) begin
            n_err++; $display("FAIL stall_next: mem_valid=%b mem_result=%h expected 1/0000000f",
                              bus.mem_valid, bus.mem_result);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        // Taken BEQ with a younger instruction waiting behind it.
        drive(32'd9, 32'd9, 32'h3, 32'h100, 3'b001, 6'h0, 1'b0, 1'b1);
        next_cycle();
        drive(32'd1, 32'd1, 32'h0, 32'h104, 3'b010, 6'h20, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h10C) begin
            n_err++; $display("FAIL beq_taken: redirect_valid=%b redirect_pc=%h expected 1/0000010c",
                              bus.redirect_valid, bus.redirect_pc);
        end
        n_vec++;
        if (bus.id_ready !== 1'b0) begin
            n_err++; $display("FAIL beq_id_ready: got %b expected 0", bus.id_ready);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (bus.redirect_valid !== 1'b0 || bus.mem_valid !== 1'b0 || bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL beq_after: redirect=%b mem_valid=%b id_ready=%b expected 0/0/1",
                              bus.redirect_valid, bus.mem_valid, bus.id_ready);
        end
        next_cycle();
        // Not-taken BEQ: normal handoff, no redirect.
        drive(32'd9, 32'd4, 32'h5, 32'h200, 3'b001, 6'h0, 1'b0, 1'b1);
        next_cycle();
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.redirect_valid !== 1'b0 || bus.mem_valid !== 1'b1 || bus.mem_result !== 32'd5) begin
            n_err++; $display("FAIL bne_path: redirect=%b mem_valid=%b mem_result=%h expected 0/1/5",
                              bus.redirect_valid, bus.mem_valid, bus.mem_result);
        end
        next_cycle();
        // Taken branch whose target wraps past 2^32.
        drive(32'd4, 32'd4, 32'h8, 32'hFFFF_FFF0, 3'b001, 6'h0, 1'b0, 1'b1);
        next_cycle();
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h10) begin
            n_err++; $display("FAIL beq_wrap: redirect=%b redirect_pc=%h expected 1/00000010",
                              bus.redirect_valid, bus.redirect_pc);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.mem_ready = 1'b0;
        drive(32'h55, 32'h22, 32'h0, 32'h0, 3'b010, 6'h20, 1'b0, 1'b0);
        next_cycle();
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_full: mem_valid=%b expected 1", bus.mem_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.mem_valid !== 1'b0 || bus.ex_a !== 32'd0) begin
            n_err++; $display("FAIL rst_mid_async: mem_valid=%b ex_a=%h expected 0/0",
                              bus.mem_valid, bus.ex_a);
        end
        exp_q.delete();
        next_cycle();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.mem_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL rst_mid_stale: stale mem_valid seen=1 expected 0");
        end
        next_cycle();
    endtask

`ifdef EX_STAGE_CTRL_MUL_EN
    task automatic test_mul();
        drive(32'hFFFF_FFFF, 32'd3, 32'h0, 32'h0, 3'b010, 6'h18, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL mul_accept: id_ready=%b expected 1", bus.id_ready);
        end
        next_cycle();
        drive(32'd2, 32'd3, 32'h0, 32'h0, 3'b010, 6'h20, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.id_ready !== 1'b0 || bus.mem_valid !== 1'b0) begin
                n_err++; $display("FAIL mul_busy[%0d]: id_ready=%b mem_valid=%b expected 0/0",
                                  i, bus.id_ready, bus.mem_valid);
            end
            next_cycle();
        end
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'hFFFF_FFFD) begin
            n_err++; $display("FAIL mul_result: mem_valid=%b mem_result=%h expected 1/fffffffd",
                              bus.mem_valid, bus.mem_result);
        end
        next_cycle();
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'd5) begin
            n_err++; $display("FAIL mul_follow: mem_valid=%b mem_result=%h expected 1/5",
                              bus.mem_valid, bus.mem_result);
        end
        next_cycle();
    endtask

    task automatic test_mul_reset();
        bit seen;
        drive(32'd6, 32'd7, 32'h0, 32'h0, 3'b010, 6'h18, 1'b0, 1'b0);
        next_cycle();
        bus.id_valid = 1'b0;
        repeat (5) next_cycle();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.mem_valid !== 1'b0 || bus.id_ready !== 1'b1) begin
            n_err++; $display("FAIL mul_rst_async: mem_valid=%b id_ready=%b expected 0/1",
                              bus.mem_valid, bus.id_ready);
        end
        exp_q.delete();
        next_cycle();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL mul_rst_stale: stale mem_valid seen=1 expected 0");
        end
        next_cycle();
    endtask
`else
    task automatic test_funct18_alu();
        drive(32'd6, 32'd7, 32'h0, 32'h0, 3'b010, 6'h18, 1'b0, 1'b0);
        next_cycle();
        bus.id_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.mem_valid !== 1'b1 || bus.mem_result !== 32'd13) begin
            n_err++; $display("FAIL funct18_alu: mem_valid=%b mem_result=%h expected 1/0000000d",
                              bus.mem_valid, bus.mem_result);
        end
        next_cycle();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_stall();
        test_branch();
        test_reset_mid();
`ifdef EX_STAGE_CTRL_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_funct18_alu();
`endif
        repeat (2) next_cycle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: %0d entries pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
